cnn_stage_sequencer: RTL and testbench

- Handshake-driven sequencer for the CNN datapath: memory load, compute and display.
- Runs the compute stage once per layer for NUM_LAYERS layers, then releases display, then returns to idle.
- Stage changes depend on done handshakes, not fixed cycle counts.
- Drives the same active-high "hold in reset" enables consumed by the memory, computation and display modules.

---
 rtl/cnn_stage_sequencer.sv | 126 ++++++++++++
 tb/tb_cnn_stage_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_stage_sequencer.sv
// Handshake-driven load/compute/display sequencer for the CNN datapath.
// Define STAGE_WATCHDOG_EN to compile in the per-wait watchdog and the ERR trap.
module cnn_stage_sequencer #(
    parameter int NUM_LAYERS = 3,
    parameter int LIDX_W     = 4,
    parameter int TIMEOUT    = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mem_done,
    input  logic              comp_done,
    input  logic              disp_ack,
    output logic              enable_memory,
    output logic              enable_compute,
    output logic              enable_display,
    output logic              comp_start,
    output logic [LIDX_W-1:0] layer_idx,
    output logic              busy,
    output logic              frame_done,
    output logic [7:0]        frame_cnt,
    output logic              error
);

    localparam logic [2:0] S_IDLE        = 3'd0;
    localparam logic [2:0] S_LOAD        = 3'd1;
    localparam logic [2:0] S_COMP_LAUNCH = 3'd2;
    localparam logic [2:0] S_COMP_WAIT   = 3'd3;
    localparam logic [2:0] S_NEXT        = 3'd4;
    localparam logic [2:0] S_DISPLAY     = 3'd5;
    localparam logic [2:0] S_DONE        = 3'd6;
    localparam logic [2:0] S_ERR         = 3'd7;

    localparam logic [LIDX_W-1:0] LAST_LAYER = LIDX_W'(NUM_LAYERS - 1);

    if (NUM_LAYERS < 1 || NUM_LAYERS > 15 || (NUM_LAYERS - 1) >= (1 << LIDX_W) ||
        TIMEOUT < 1 || TIMEOUT > 1023) begin : g_cfg_check
        $error("cnn_stage_sequencer: illegal parameter combination");
    end

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [LIDX_W-1:0] layer_q;
    logic              wd_expire;

`ifdef STAGE_WATCHDOG_EN
    localparam logic [9:0] WD_LAST = 10'(TIMEOUT - 1);
    logic [9:0] wd_cnt;

    // Cycle k of a wait holds k-1, so the compare fires on the TIMEOUT-th cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wd_cnt <= '0;
        end else if (state_nxt != state) begin
            wd_cnt <= '0;
        end else if (state == S_LOAD || state == S_COMP_WAIT || state == S_DISPLAY) begin
            wd_cnt <= wd_cnt + 10'd1;
        end
    end

    assign wd_expire = (wd_cnt == WD_LAST);
`else
    assign wd_expire = 1'b0;
`endif

    // Done inputs are tested before the watchdog so a coincident done wins.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:        if (start) state_nxt = S_LOAD;
            S_LOAD:        if (mem_done) state_nxt = S_COMP_LAUNCH;
                           else if (wd_expire) state_nxt = S_ERR;
            S_COMP_LAUNCH: state_nxt = S_COMP_WAIT;
            S_COMP_WAIT:   if (comp_done) state_nxt = S_NEXT;
                           else if (wd_expire) state_nxt = S_ERR;
            S_NEXT:        state_nxt = (layer_q == LAST_LAYER) ? S_DISPLAY : S_COMP_LAUNCH;
            S_DISPLAY:     if (disp_ack) state_nxt = S_DONE;
                           else if (wd_expire) state_nxt = S_ERR;
            S_DONE:        state_nxt = S_IDLE;
            S_ERR:         state_nxt = S_ERR;
            default:       state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= S_IDLE;
            layer_q <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt == S_IDLE) begin
                layer_q <= '0;
            end else if (state == S_NEXT && layer_q != LAST_LAYER) begin
                layer_q <= layer_q + 1'b1;
            end
        end
    end

    // Every output is a registered decode of the state present in the previous cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            enable_memory  <= 1'b1;
            enable_compute <= 1'b1;
            enable_display <= 1'b1;
            comp_start     <= 1'b0;
            layer_idx      <= '0;
            busy           <= 1'b0;
            frame_done     <= 1'b0;
            frame_cnt      <= '0;
            error          <= 1'b0;
        end else begin
            enable_memory  <= (state == S_IDLE) || (state == S_ERR);
            enable_compute <= (state == S_IDLE) || (state == S_LOAD) || (state == S_ERR);
            enable_display <= !((state == S_DISPLAY) || (state == S_DONE));
            comp_start     <= (state == S_COMP_LAUNCH);
            layer_idx      <= layer_q;
            busy           <= (state != S_IDLE);
            frame_done     <= (state == S_DONE);
            error          <= (state == S_ERR);
            if (state == S_DONE) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_cnn_stage_sequencer.sv
// Directed bench for cnn_stage_sequencer: vector table plus multi-cycle sequences.
module tb_cnn_stage_sequencer;

    localparam int N_LAYERS   = 3;
    localparam int WD_TIMEOUT = 20;

    logic       clk;
    logic       rst;
    logic       start;
    logic       mem_done;
    logic       comp_done;
    logic       disp_ack;
    logic       enable_memory;
    logic       enable_compute;
    logic       enable_display;
    logic       comp_start;
    logic [3:0] layer_idx;
    logic       busy;
    logic       frame_done;
    logic [7:0] frame_cnt;
    logic       error;

    int n_checks = 0;
    int n_fail   = 0;

    cnn_stage_sequencer #(
        .NUM_LAYERS(N_LAYERS),
        .LIDX_W    (4),
        .TIMEOUT   (WD_TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .mem_done      (mem_done),
        .comp_done     (comp_done),
        .disp_ack      (disp_ack),
        .enable_memory (enable_memory),
        .enable_compute(enable_compute),
        .enable_display(enable_display),
        .comp_start    (comp_start),
        .layer_idx     (layer_idx),
        .busy          (busy),
        .frame_done    (frame_done),
        .frame_cnt     (frame_cnt),
        .error         (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] in;    // {rst, start, mem_done, comp_done, disp_ack}
        logic [2:0] en;    // {memory, compute, display}
        logic       cs;
        logic [3:0] li;
        logic       busy;
        logic       fd;
        logic [7:0] fc;
        logic       err;
    } vec_t;

    vec_t tbl[23];

    function automatic vec_t mk(input logic [4:0] in, input logic [2:0] en, input logic cs,
                                input logic [3:0] li, input logic bz, input logic fd,
                                input logic [7:0] fc);
        vec_t v;
        v.in = in; v.en = en; v.cs = cs; v.li = li;
        v.busy = bz; v.fd = fd; v.fc = fc; v.err = 1'b0;
        return v;
    endfunction

    function automatic logic [18:0] pack_exp(input logic [2:0] en, input logic cs,
                                             input logic [3:0] li, input logic bz,
                                             input logic fd, input logic [7:0] fc,
                                             input logic er);
        return {en, cs, li, bz, fd, fc, er};
    endfunction

    function automatic logic [18:0] dut_outs();
        return {enable_memory, enable_compute, enable_display, comp_start, layer_idx,
                busy, frame_done, frame_cnt, error};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    initial begin
        int         fc_exp;
        int         cs_n;
        int         fd_n;
        int         cs_age;
        int         disp_age;
        int         idle_after;
        int         lat;
        int         frames_ok;
        logic [3:0] seen_idx[3];
        logic       found;

        rst = 1'b0; start = 1'b0; mem_done = 1'b0; comp_done = 1'b0; disp_ack = 1'b0;

        // Each row: inputs held for one cycle, outputs reflect the state of that cycle.
        tbl[0]  = mk(5'b00000, 3'b111, 0, 0, 0, 0, 0);
        tbl[1]  = mk(5'b00000, 3'b111, 0, 0, 0, 0, 0);
        tbl[2]  = mk(5'b10000, 3'b111, 0, 0, 0, 0, 0);
        tbl[3]  = mk(5'b10000, 3'b111, 0, 0, 0, 0, 0);
        tbl[4]  = mk(5'b11000, 3'b111, 0, 0, 0, 0, 0);
        tbl[5]  = mk(5'b10000, 3'b011, 0, 0, 1, 0, 0);
        tbl[6]  = mk(5'b10010, 3'b011, 0, 0, 1, 0, 0);
        tbl[7]  = mk(5'b10100, 3'b011, 0, 0, 1, 0, 0);
        tbl[8]  = mk(5'b10000, 3'b001, 1, 0, 1, 0, 0);
        tbl[9]  = mk(5'b11000, 3'b001, 0, 0, 1, 0, 0);
        tbl[10] = mk(5'b10010, 3'b001, 0, 0, 1, 0, 0);
        tbl[11] = mk(5'b10000, 3'b001, 0, 0, 1, 0, 0);
        tbl[12] = mk(5'b10000, 3'b001, 1, 1, 1, 0, 0);
        tbl[13] = mk(5'b10010, 3'b001, 0, 1, 1, 0, 0);
        tbl[14] = mk(5'b10000, 3'b001, 0, 1, 1, 0, 0);
        tbl[15] = mk(5'b10000, 3'b001, 1, 2, 1, 0, 0);
        tbl[16] = mk(5'b10010, 3'b001, 0, 2, 1, 0, 0);
        tbl[17] = mk(5'b10000, 3'b001, 0, 2, 1, 0, 0);
        tbl[18] = mk(5'b10000, 3'b000, 0, 2, 1, 0, 0);
        tbl[19] = mk(5'b10010, 3'b000, 0, 2, 1, 0, 0);
        tbl[20] = mk(5'b10001, 3'b000, 0, 2, 1, 0, 0);
        tbl[21] = mk(5'b10000, 3'b000, 0, 2, 1, 1, 1);
        tbl[22] = mk(5'b10000, 3'b111, 0, 0, 0, 0, 1);

        for (int i = 0; i < 23; i++) begin
            {rst, start, mem_done, comp_done, disp_ack} = tbl[i].in;
            tick();
            check($sformatf("table_row_%0d", i), 32'(dut_outs()),
                  32'(pack_exp(tbl[i].en, tbl[i].cs, tbl[i].li, tbl[i].busy,
                               tbl[i].fd, tbl[i].fc, tbl[i].err)));
        end
        {rst, start, mem_done, comp_done, disp_ack} = 5'b10000;
        fc_exp = 1;

        // Frame with realistic handshake delays.
        cs_n = 0; fd_n = 0; cs_age = -1; disp_age = 0; idle_after = 0;
        seen_idx[0] = 4'hf; seen_idx[1] = 4'hf; seen_idx[2] = 4'hf;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 1; t <= 200; t++) begin
            mem_done  = (t >= 5) && (cs_n == 0);
            comp_done = (cs_age == 3);
            disp_ack  = (disp_age >= 4) && (fd_n == 0);
            tick();
            if (comp_start) begin
                if (cs_n < 3) seen_idx[cs_n] = layer_idx;
                cs_n++;
                cs_age = 0;
            end else if (cs_age >= 0) begin
                cs_age++;
            end
            if (!enable_display) disp_age++;
            if (frame_done) fd_n++;
            if (fd_n > 0) begin
                idle_after++;
                if (idle_after == 4) break;
            end
        end
        mem_done = 1'b0; comp_done = 1'b0; disp_ack = 1'b0;
        fc_exp++;
        check("timed_comp_start_count", 32'(cs_n), 32'd3);
        check("timed_layer0", 32'(seen_idx[0]), 32'd0);
        check("timed_layer1", 32'(seen_idx[1]), 32'd1);
        check("timed_layer2", 32'(seen_idx[2]), 32'd2);
        check("timed_frame_done_count", 32'(fd_n), 32'd1);
        check("timed_frame_cnt", 32'(frame_cnt), 32'(fc_exp));
        check("timed_enables_idle", 32'({enable_memory, enable_compute, enable_display, busy}),
              32'b1110);

        // Minimum latency with every done held high.
        lat = 0;
        start = 1'b1; mem_done = 1'b1; comp_done = 1'b1; disp_ack = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (k == 1) start = 1'b0;
            if (frame_done) begin
                lat = k;
                break;
            end
        end
        mem_done = 1'b0; comp_done = 1'b0; disp_ack = 1'b0;
        fc_exp++;
        check("min_latency", 32'(lat), 32'(4 + 3 * N_LAYERS));
        check("min_latency_frame_cnt", 32'(frame_cnt), 32'(fc_exp));

        // Mid-frame reset while waiting on layer 1.
        found = 1'b0;
        start = 1'b1; mem_done = 1'b1; comp_done = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (comp_start && layer_idx == 4'd1) begin
                found = 1'b1;
                break;
            end
        end
        mem_done = 1'b0; comp_done = 1'b0;
        check("midreset_reached_layer1", 32'(found), 32'd1);
        rst = 1'b0;
        tick();
        fc_exp = 0;
        check("midreset_outputs", 32'(dut_outs()), 32'(pack_exp(3'b111, 0, 0, 0, 0, 0, 0)));
        rst = 1'b1;
        tick();
        check("midreset_stays_idle", 32'(dut_outs()), 32'(pack_exp(3'b111, 0, 0, 0, 0, 0, 0)));
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("restart_load", 32'(dut_outs()), 32'(pack_exp(3'b011, 0, 0, 1, 0, 0, 0)));
        mem_done = 1'b1;
        tick();
        mem_done = 1'b0;
        tick();
        check("restart_layer0_launch", 32'(dut_outs()), 32'(pack_exp(3'b001, 1, 0, 1, 0, 0, 0)));
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();

        // 256 back-to-back frames: counter wraps to zero.
        frames_ok = 0;
        for (int f = 1; f <= 256; f++) begin
            found = 1'b0;
            start = 1'b1; mem_done = 1'b1; comp_done = 1'b1; disp_ack = 1'b1;
            for (int k = 1; k <= 60; k++) begin
                tick();
                if (k == 1) start = 1'b0;
                if (frame_done) begin
                    found = 1'b1;
                    break;
                end
            end
            if (found) frames_ok++;
            if (f == 255) check("wrap_cnt_255", 32'(frame_cnt), 32'd255);
        end
        mem_done = 1'b0; comp_done = 1'b0; disp_ack = 1'b0;
        check("wrap_frames_completed", 32'(frames_ok), 32'd256);
        check("wrap_cnt_0", 32'(frame_cnt), 32'd0);
        check("wrap_error_low", 32'(error), 32'd0);

`ifdef STAGE_WATCHDOG_EN
        begin
            int   err_at;
            logic sticky;
            rst = 1'b0;
            tick();
            rst = 1'b1;
            tick();
            err_at = 0;
            sticky = 1'b1;
            start = 1'b1;
            tick();
            start = 1'b0;
            for (int c = 2; c <= 45; c++) begin
                mem_done = (c == 35);
                tick();
                if (error && err_at == 0) err_at = c;
                if (err_at != 0 && !error) sticky = 1'b0;
            end
            mem_done = 1'b0;
            check("wd_error_cycle", 32'(err_at), 32'(WD_TIMEOUT + 2));
            check("wd_error_sticky", 32'(sticky), 32'd1);
            check("wd_err_outputs", 32'({enable_memory, enable_compute, enable_display, busy, error}),
                  32'b11111);
            rst = 1'b0;
            tick();
            check("wd_reset_clears", 32'(error), 32'd0);
            rst = 1'b1;
            tick();
            found = 1'b0;
            sticky = 1'b0;
            start = 1'b1;
            tick();
            start = 1'b0;
            for (int c = 1; c <= 30; c++) begin
                mem_done = (c == WD_TIMEOUT);
                tick();
                if (error) sticky = 1'b1;
                if (comp_start) begin
                    found = 1'b1;
                    break;
                end
            end
            mem_done = 1'b0;
            check("wd_done_wins_launch", 32'(found), 32'd1);
            check("wd_done_wins_no_error", 32'(sticky), 32'd0);
            rst = 1'b0;
            tick();
            rst = 1'b1;
            tick();
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
